// File: rtl/branch_target_buffer_pkg.sv
// Shared types and helpers for the branch target buffer: FSM state
// encoding, saturating-counter reference values and PC field extraction.
package branch_target_buffer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } btb_state_t;

   // Saturation ceiling of a ctr_w-bit direction counter.
   function automatic int ctr_max(input int ctr_w);
      return (1 << ctr_w) - 1;
   endfunction

   // Lowest counter value that predicts taken (allocation value).
   function automatic int ctr_weak_t(input int ctr_w);
      return 1 << (ctr_w - 1);
   endfunction

   // Highest counter value that predicts not taken (reset value).
   function automatic int ctr_weak_nt(input int ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

   // Entry index: the word-address bits just above the byte offset.
   function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
      return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   // Entry tag: every PC bit above the index field.
   function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
      return pc >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/branch_target_buffer_sat_ctr.sv
// Next value of a saturating up/down direction counter given the
// resolved branch outcome.
module btb_sat_ctr
   import branch_target_buffer_pkg::*;
#(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_next
);

   localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));

   // Count toward the outcome, holding at the ends of the range.
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_MAX) ctr_next = ctr + 1'b1;
      end else begin
         if (ctr != '0) ctr_next = ctr - 1'b1;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup for fetch,
// resolved-branch write-back from decode, and a one-entry-per-cycle
// invalidate-all sweep.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int PC_W    = 32,
   parameter int CTR_W   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] lk_pc,
   output logic            lk_hit,
   output logic            lk_taken,
   output logic [PC_W-1:0] lk_target,
   input  logic            up_valid,
   input  logic [PC_W-1:0] up_pc,
   input  logic            up_taken,
   input  logic [PC_W-1:0] up_target,
   input  logic            inv_req,
   output logic            busy
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ENTRIES - 1);

   btb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   logic [PC_W-1:0]  target_d [ENTRIES];
   logic [CTR_W-1:0] ctr_q    [ENTRIES];
   logic [CTR_W-1:0] ctr_d    [ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit, up_en, alloc, hit_upd;
   logic [CTR_W-1:0] ctr_nxt;

   assign lk_idx = IDX_W'(pc_index(64'(lk_pc), IDX_W));
   assign lk_tag = TAG_W'(pc_tag(64'(lk_pc), IDX_W));
   assign up_idx = IDX_W'(pc_index(64'(up_pc), IDX_W));
   assign up_tag = TAG_W'(pc_tag(64'(up_pc), IDX_W));

   assign busy = (state_q == SWEEP);

   // Updates are only accepted while idle and no sweep is being requested.
   assign up_en   = up_valid && (state_q == IDLE) && !inv_req;
   assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign alloc   = up_en && !up_hit && up_taken;
   assign hit_upd = up_en && up_hit;

   btb_sat_ctr #(
      .CTR_W(CTR_W)
   ) u_sat_ctr (
      .ctr      (ctr_q[up_idx]),
      .taken    (up_taken),
      .ctr_next (ctr_nxt)
   );

   // Lookup: pure read of the current contents, forced to miss during a sweep.
   always_comb begin
      lk_hit    = 1'b0;
      lk_taken  = 1'b0;
      lk_target = '0;
      if (!busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
         lk_hit    = 1'b1;
         lk_taken  = ctr_q[lk_idx][CTR_W-1];
         lk_target = target_q[lk_idx];
      end
   end

   // Sweep sequencer: walk ptr across every entry once, then return to idle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (inv_req) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end
         end
         SWEEP: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_IDX) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Entry next-state: sweep clears one valid bit; updates allocate or train.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_d[i]  = valid_q[i];
         tag_d[i]    = tag_q[i];
         target_d[i] = target_q[i];
         ctr_d[i]    = ctr_q[i];
      end
      if (state_q == SWEEP) valid_d[ptr_q] = 1'b0;
      if (alloc) begin
         valid_d[up_idx]  = 1'b1;
         tag_d[up_idx]    = up_tag;
         target_d[up_idx] = up_target;
         ctr_d[up_idx]    = CTR_WEAK_T;
      end else if (hit_upd) begin
         ctr_d[up_idx] = ctr_nxt;
         if (up_taken) target_d[up_idx] = up_target;
      end
   end

   // State and storage registers; reset wins over sweep and update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WEAK_NT;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= valid_d[i];
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (ENTRIES=8, CTR_W=2): the
// driver queues the expected lookup response with each probe, and a
// monitor compares it on the falling edge of the same cycle.
module tb_branch_target_buffer;

   logic        clk;
   logic        reset;
   logic [31:0] lk_pc;
   logic        lk_hit;
   logic        lk_taken;
   logic [31:0] lk_target;
   logic        up_valid;
   logic [31:0] up_pc;
   logic        up_taken;
   logic [31:0] up_target;
   logic        inv_req;
   logic        busy;

   typedef struct packed {
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic        busy;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   logic  lk_chk;
   int    tests;
   int    fails;

   branch_target_buffer #(
      .ENTRIES(8),
      .PC_W   (32),
      .CTR_W  (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .lk_pc     (lk_pc),
      .lk_hit    (lk_hit),
      .lk_taken  (lk_taken),
      .lk_target (lk_target),
      .up_valid  (up_valid),
      .up_pc     (up_pc),
      .up_taken  (up_taken),
      .up_target (up_target),
      .inv_req   (inv_req),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare the DUT response against the queued expectation.
   always @(negedge clk) begin
      if (lk_chk) begin
         exp_t  e;
         string nm;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL monitor: probe with empty expectation queue");
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if ({lk_hit, lk_taken, lk_target, busy} !== e) begin
               fails++;
               $display("FAIL %s: got hit=%0b taken=%0b target=%h busy=%0b, expected hit=%0b taken=%0b target=%h busy=%0b",
                        nm, lk_hit, lk_taken, lk_target, busy, e.hit, e.taken, e.target, e.busy);
            end else begin
               $display("[TB] %-16s pc=%h hit=%0b taken=%0b target=%h busy=%0b",
                        nm, lk_pc, lk_hit, lk_taken, lk_target, busy);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      up_valid = 1'b0;
      inv_req  = 1'b0;
      lk_chk   = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      up_valid  = 1'b1;
      up_pc     = pc;
      up_taken  = tk;
      up_target = tgt;
   endtask

   task automatic look(input string nm, input logic [31:0] pc, input logic h,
                       input logic t, input logic [31:0] tg, input logic b);
      exp_t e;
      e.hit    = h;
      e.taken  = t;
      e.target = tg;
      e.busy   = b;
      lk_pc    = pc;
      exp_q.push_back(e);
      name_q.push_back(nm);
      lk_chk   = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; lk_chk = 1'b0;
      reset = 1'b0; lk_pc = '0; up_valid = 1'b0; up_pc = '0;
      up_taken = 1'b0; up_target = '0; inv_req = 1'b0;
      tick(); tick();
      reset = 1'b1;

      // Reset state
      look("reset", 32'h40, 0, 0, 32'h0, 0); tick();

      // Allocate: same-cycle lookup sees old contents
      upd(32'h40, 1, 32'h100); look("alloc_same", 32'h40, 0, 0, 32'h0, 0); tick();
      look("alloc", 32'h40, 1, 1, 32'h100, 0); tick();

      // Not-taken training down to the floor (ctr 2 -> 1 -> 0 -> 0)
      upd(32'h40, 0, 32'hdead); look("nt1_same", 32'h40, 1, 1, 32'h100, 0); tick();
      upd(32'h40, 0, 32'hdead); look("nt2_same", 32'h40, 1, 0, 32'h100, 0); tick();
      look("ctr0", 32'h40, 1, 0, 32'h100, 0); upd(32'h40, 0, 32'hdead); tick();
      look("floor", 32'h40, 1, 0, 32'h100, 0); tick();

      // Taken training up to the ceiling (0 -> 1 -> 2 -> 3 -> 3)
      upd(32'h40, 1, 32'h104); tick();
      look("ctr1", 32'h40, 1, 0, 32'h104, 0); upd(32'h40, 1, 32'h108); tick();
      look("ctr2", 32'h40, 1, 1, 32'h108, 0); upd(32'h40, 1, 32'h108); tick();
      upd(32'h40, 1, 32'h108); tick();
      // Saturated at 3: one not-taken keeps the prediction taken, second flips it
      upd(32'h40, 0, 32'hdead); tick();
      look("ceil_nt1", 32'h40, 1, 1, 32'h108, 0); upd(32'h40, 0, 32'hdead); tick();
      look("ceil_nt2", 32'h40, 1, 0, 32'h108, 0); tick();

      // Alias at index 0 with a different tag overwrites the entry
      upd(32'h60, 1, 32'h200); tick();
      look("alias_old", 32'h40, 0, 0, 32'h0, 0); tick();
      look("alias_new", 32'h60, 1, 1, 32'h200, 0); upd(32'h60, 0, 32'hdead); tick();
      look("alias_ctr1", 32'h60, 1, 0, 32'h200, 0); tick();

      // Not-taken miss does not allocate
      upd(32'h44, 0, 32'h300); tick();
      look("nt_miss", 32'h44, 0, 0, 32'h0, 0); tick();

      // Sweep started together with an update; the update is dropped
      inv_req = 1'b1; upd(32'h48, 1, 32'h400);
      look("sweep_req", 32'h60, 1, 0, 32'h200, 0); tick();
      for (int c = 0; c < 8; c++) begin
         look($sformatf("sweep_c%0d", c), 32'h60, 0, 0, 32'h0, 1);
         if (c == 3) inv_req = 1'b1;
         if (c == 5) upd(32'h4c, 1, 32'h500);
         tick();
      end
      look("post_60", 32'h60, 0, 0, 32'h0, 0); upd(32'h4c, 1, 32'h500); tick();
      look("post_48", 32'h48, 0, 0, 32'h0, 0); tick();
      look("post_40", 32'h40, 0, 0, 32'h0, 0); tick();
      look("first_upd", 32'h4c, 1, 1, 32'h500, 0); tick();

      // Reset in the middle of a sweep
      upd(32'h54, 1, 32'h700); tick();
      look("pre_54", 32'h54, 1, 1, 32'h700, 0); inv_req = 1'b1; tick();
      for (int c = 0; c < 3; c++) begin
         look($sformatf("rsweep_c%0d", c), 32'h54, 0, 0, 32'h0, 1);
         tick();
      end
      reset = 1'b0; tick();
      reset = 1'b1;
      look("rst_54", 32'h54, 0, 0, 32'h0, 0); tick();
      look("rst_4c", 32'h4c, 0, 0, 32'h0, 0); upd(32'h40, 1, 32'h600); tick();
      look("rst_alloc", 32'h40, 1, 1, 32'h600, 0); upd(32'h40, 0, 32'hdead); tick();
      look("rst_ctr1", 32'h40, 1, 0, 32'h600, 0); tick();

      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
